// File: rtl/nv_arb2_pipe_if.sv
// Handshake bundle for nv_arb2_pipe: two valid/ready requesters in, one registered pipe out.
// The arbiter uses the slave modport; the block driving the requesters uses the master modport.
interface nv_arb2_pipe_if #(
   parameter int DW = 32
);
   logic          in0_pvld;
   logic          in0_prdy;
   logic [DW-1:0] in0_pd;
   logic          in0_plast;
   logic          in1_pvld;
   logic          in1_prdy;
   logic [DW-1:0] in1_pd;
   logic          in1_plast;
   logic          out_pvld;
   logic          out_prdy;
   logic [DW-1:0] out_pd;
   logic          out_plast;
   logic          out_src;

   modport master (
      output in0_pvld, in0_pd, in0_plast,
      output in1_pvld, in1_pd, in1_plast,
      output out_prdy,
      input  in0_prdy, in1_prdy,
      input  out_pvld, out_pd, out_plast, out_src
   );

   modport slave (
      input  in0_pvld, in0_pd, in0_plast,
      input  in1_pvld, in1_pd, in1_plast,
      input  out_prdy,
      output in0_prdy, in1_prdy,
      output out_pvld, out_pd, out_plast, out_src
   );
endinterface

// File: rtl/nv_arb2_pipe.sv
// Packet-aware two-input round-robin arbiter with one registered output stage.
// Optional NV_ARB2_PIPE_STARVE_EN adds 4-bit per-channel starvation counters.
module nv_arb2_pipe #(
   parameter int DW       = 32,
   parameter int INIT_PRI = 0
) (
   input logic           nvdla_core_clk,
   input logic           nvdla_core_rstn,
   nv_arb2_pipe_if.slave bus
);

   typedef enum logic {ST_OPEN, ST_LOCKED} lockState_e;

   lockState_e    lockState_q, lockState_d;
   logic          lockCh_q,    lockCh_d;
   logic          pri_q,       pri_d;
   logic          outPvld_q,   outPvld_d;
   logic [DW-1:0] outPd_q,     outPd_d;
   logic          outPlast_q,  outPlast_d;
   logic          outSrc_q,    outSrc_d;

   logic          pipeEn;
   logic          gntVld;
   logic          gntCh;
   logic          acc;
   logic          accLast;
   logic [DW-1:0] accPd;

`ifdef NV_ARB2_PIPE_STARVE_EN
   logic [3:0] starve0_q, starve0_d;
   logic [3:0] starve1_q, starve1_d;
   logic       favour0, favour1;

   assign favour0 = (starve0_q == 4'hF) && (starve1_q != 4'hF);
   assign favour1 = (starve1_q == 4'hF) && (starve0_q != 4'hF);
`endif

   assign pipeEn = !outPvld_q || bus.out_prdy;

   // A held lock grants its owner even while the owner is idle, so the other channel sees a bubble.
   always_comb begin
      gntVld = 1'b0;
      gntCh  = pri_q;
      if (lockState_q == ST_LOCKED) begin
         gntVld = 1'b1;
         gntCh  = lockCh_q;
      end else if (bus.in0_pvld && bus.in1_pvld) begin
         gntVld = 1'b1;
         gntCh  = pri_q;
`ifdef NV_ARB2_PIPE_STARVE_EN
         if (favour0) begin
            gntCh = 1'b0;
         end else if (favour1) begin
            gntCh = 1'b1;
         end
`endif
      end else if (bus.in0_pvld) begin
         gntVld = 1'b1;
         gntCh  = 1'b0;
      end else if (bus.in1_pvld) begin
         gntVld = 1'b1;
         gntCh  = 1'b1;
      end
   end

   assign bus.in0_prdy = pipeEn && gntVld && !gntCh;
   assign bus.in1_prdy = pipeEn && gntVld &&  gntCh;

   assign acc     = pipeEn && gntVld && (gntCh ? bus.in1_pvld : bus.in0_pvld);
   assign accPd   = gntCh ? bus.in1_pd    : bus.in0_pd;
   assign accLast = gntCh ? bus.in1_plast : bus.in0_plast;

   always_comb begin
      lockState_d = lockState_q;
      lockCh_d    = lockCh_q;
      pri_d       = pri_q;
      outPvld_d   = outPvld_q;
      outPd_d     = outPd_q;
      outPlast_d  = outPlast_q;
      outSrc_d    = outSrc_q;
      if (acc) begin
         outPvld_d  = 1'b1;
         outPd_d    = accPd;
         outPlast_d = accLast;
         outSrc_d   = gntCh;
         if (accLast) begin
            lockState_d = ST_OPEN;
            pri_d       = ~gntCh;
         end else begin
            lockState_d = ST_LOCKED;
            lockCh_d    = gntCh;
         end
      end else if (pipeEn) begin
         outPvld_d = 1'b0;
      end
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         lockState_q <= ST_OPEN;
         lockCh_q    <= 1'b0;
         pri_q       <= 1'(INIT_PRI);
         outPvld_q   <= 1'b0;
         outPd_q     <= '0;
         outPlast_q  <= 1'b0;
         outSrc_q    <= 1'b0;
      end else begin
         lockState_q <= lockState_d;
         lockCh_q    <= lockCh_d;
         pri_q       <= pri_d;
         outPvld_q   <= outPvld_d;
         outPd_q     <= outPd_d;
         outPlast_q  <= outPlast_d;
         outSrc_q    <= outSrc_d;
      end
   end

`ifdef NV_ARB2_PIPE_STARVE_EN
   // Counters saturate at 15 and only count cycles where the output could have taken a beat.
   always_comb begin
      starve0_d = starve0_q;
      starve1_d = starve1_q;
      if (gntVld && !gntCh) begin
         starve0_d = 4'd0;
      end else if (bus.in0_pvld && pipeEn && (starve0_q != 4'hF)) begin
         starve0_d = starve0_q + 4'd1;
      end
      if (gntVld && gntCh) begin
         starve1_d = 4'd0;
      end else if (bus.in1_pvld && pipeEn && (starve1_q != 4'hF)) begin
         starve1_d = starve1_q + 4'd1;
      end
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         starve0_q <= 4'd0;
         starve1_q <= 4'd0;
      end else begin
         starve0_q <= starve0_d;
         starve1_q <= starve1_d;
      end
   end
`endif

   assign bus.out_pvld  = outPvld_q;
   assign bus.out_pd    = outPd_q;
   assign bus.out_plast = outPlast_q;
   assign bus.out_src   = outSrc_q;

endmodule
